uart_rx_fifo: RTL

- UART receiver with a receive FIFO. It sits directly downstream of the board RX pin and upstream of the memory-mapped peripheral register file.
- Deframes 8N1 serial bytes using 16x oversampling and buffers them in a FIFO.
- The CPU pops bytes through a single-cycle read strobe decoded by the peripheral on a load from the UART RX address. An interrupt request level tells the CPU that data is waiting.

---
 rtl/uart_rx_fifo_if.sv | 34 +++
 rtl/uart_rx_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// CPU-side bus of the UART receiver: pop/clear strobes, FIFO status and error flags.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic                  rd_en;
    logic                  err_clr;
    logic [7:0]            rd_data;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  irq;
    logic                  frame_err;
    logic                  overrun_err;
`ifdef UART_RX_PARITY_EN
    logic                  parity_err;
`endif

    modport master (
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        output rd_en, err_clr,
        input  rd_data, empty, full, count, irq, frame_err, overrun_err
    );

    modport slave (
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        input  rd_en, err_clr,
        output rd_data, empty, full, count, irq, frame_err, overrun_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with 16x oversampling feeding a show-ahead receive FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit and drive parity_err.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    uart_rx_fifo_if.slave bus
);
    localparam int DIV   = CLK_HZ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic sync_q, rxs_q, rxs_dly_q;

    // NOTE: every clocked block uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 1'b1;
            rxs_q     <= 1'b1;
            rxs_dly_q <= 1'b1;
        end else begin
            sync_q    <= rx;
            rxs_q     <= sync_q;
            rxs_dly_q <= rxs_q;
        end
    end

    logic [2:0]       state_q, state_d;
    logic [3:0]       scnt_q, scnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             push_q, push_d;
    logic             ferr_set;
    logic             tick, start_edge;
`ifdef UART_RX_PARITY_EN
    logic             perr_set;
    logic             parity_err_q;
`endif

    // Divider free-runs, but restarts on the start edge so samples land mid-bit.
    assign start_edge = (state_q == S_IDLE) && rxs_dly_q && !rxs_q;
    assign tick       = (div_q == DIV_W'(DIV - 1));
    assign div_d      = (tick || start_edge) ? '0 : div_q + DIV_W'(1);

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        scnt_d   = scnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        push_d   = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_set = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_START;
                    scnt_d  = 4'd0;
                end
            end
            S_START: begin
                if (tick) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd7) begin
                        scnt_d  = 4'd0;
                        bit_d   = 3'd0;
                        state_d = rxs_q ? S_IDLE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        shreg_d = {rxs_q, shreg_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        perr_set = rxs_q ^ (^shreg_q);
                        state_d  = S_STOP;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        push_d   = rxs_q;
                        ferr_set = !rxs_q;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            scnt_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            div_q   <= '0;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            div_q   <= div_d;
            push_q  <= push_d;
        end
    end

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_inc;
    logic [CW-1:0]         count_q, count_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic                  irq_q, frame_err_q, overrun_err_q;
    logic                  do_pop, do_push, overrun_set;

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign do_pop      = bus.rd_en && (count_q != '0);
    assign do_push     = push_q && ((count_q != CW'(DEPTH)) || do_pop);
    assign overrun_set = push_q && !do_push;
    assign rd_ptr_inc  = rd_ptr_q + DEPTH_LOG2'(1);

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (do_pop) begin
            rd_ptr_d  = rd_ptr_inc;
            rd_data_d = (do_push && count_q == CW'(1)) ? shreg_q : mem_q[rd_ptr_inc];
        end else if (do_push && count_q == '0) begin
            rd_data_d = shreg_q;
        end
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    // NOTE: storage has no reset; rd_data_q and the pointers alone define what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= shreg_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            rd_data_q     <= '0;
            irq_q         <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            rd_data_q     <= rd_data_d;
            irq_q         <= (count_q != '0);
            frame_err_q   <= ferr_set    || (frame_err_q   && !bus.err_clr);
            overrun_err_q <= overrun_set || (overrun_err_q && !bus.err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) parity_err_q <= 1'b0;
        else       parity_err_q <= perr_set || (parity_err_q && !bus.err_clr);
    end
    assign bus.parity_err = parity_err_q;
`endif

    assign bus.rd_data     = rd_data_q;
    assign bus.empty       = (count_q == '0);
    assign bus.full        = (count_q == CW'(DEPTH));
    assign bus.count       = count_q;
    assign bus.irq         = irq_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.overrun_err = overrun_err_q;
endmodule
